// File: rtl/warn_serializer.sv
// warn_serializer: parallel-to-serial transmitter with a start bit, DATA_W data
// bits sent LSB first, and a stop bit. Each bit is held for CLKS_PER_BIT clocks.
// The line idles high.
// Optional feature: define WARN_SERIALIZER_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit.
module warn_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

`ifdef WARN_SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [BIT_W-1:0]  bit_idx;
  logic [BIT_W-1:0]  bit_nxt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic              tx_nxt;
  logic              bit_done;
`ifdef WARN_SERIALIZER_PARITY_EN
  logic              parity;
  logic              parity_nxt;
`endif

  // Handshake and status depend only on the registered state.
  assign din_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State, counters, shift register and the registered serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
`ifdef WARN_SERIALIZER_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
`ifdef WARN_SERIALIZER_PARITY_EN
      parity  <= parity_nxt;
`endif
    end
  end

  // Next-state logic: each bit period ends when the cycle counter reaches
  // CLKS_PER_BIT-1; the data register shifts right once per data bit so the
  // bit on the line is always shift[0]. din is only looked at in IDLE, so a
  // frame in flight cannot be disturbed by later changes on din.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_idx;
    shift_nxt  = shift;
`ifdef WARN_SERIALIZER_PARITY_EN
    parity_nxt = parity;
`endif
    bit_done   = (cnt == CNT_MAX);

    case (state)
      IDLE: begin
        if (din_valid) begin
          state_nxt  = START;
          cnt_nxt    = '0;
          bit_nxt    = '0;
          shift_nxt  = din;
`ifdef WARN_SERIALIZER_PARITY_EN
          parity_nxt = ^din;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_nxt   = '0;
          shift_nxt = shift >> 1;
          if (bit_idx == BIT_MAX) begin
            bit_nxt = '0;
`ifdef WARN_SERIALIZER_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef WARN_SERIALIZER_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // Line value for the coming cycle, derived from the next state so that the
  // start bit appears on the cycle right after the transfer edge while tx
  // itself stays a flop output.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      IDLE:   tx_nxt = 1'b1;
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = shift_nxt[0];
`ifdef WARN_SERIALIZER_PARITY_EN
      PARITY: tx_nxt = parity_nxt;
`endif
      STOP:   tx_nxt = 1'b1;
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: doc/warn_serializer.md
WARN_SERIALIZER -- requirements
Module: warn_serializer

Interface
REQ-001 Parameter: DATA_W, 8, width of parallel input word.
REQ-002 Parameter: CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: din  input  DATA_W  parallel word to transmit.
REQ-006 Port: din_valid  input  1  din holds a word to send.
REQ-007 Port: din_ready  output  1  block can accept a word this cycle.
REQ-008 Port: tx  output  1  serial line, idle high.
REQ-009 Port: busy  output  1  frame in progress.

Function
REQ-010 Transfer SHALL occur on a posedge where din_valid and din_ready are both 1; din SHALL be captured into a shift register on that edge.
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY exists only when the Configuration macro is defined.
REQ-012 In IDLE, din_ready=1, busy=0, tx=1; a transfer SHALL move to START on the same edge.
REQ-013 In every state other than IDLE, din_ready=0 and busy=1; din_valid SHALL be ignored.
REQ-014 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-015 DATA SHALL drive DATA_W bits LSB first, each for exactly CLKS_PER_BIT cycles, using a bit counter 0..DATA_W-1.
REQ-016 After the last data bit, the FSM SHALL enter PARITY (if compiled in) or STOP.
REQ-017 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles, then return to IDLE.
REQ-018 tx SHALL be a registered output (no combinational path from din or din_valid to tx).
REQ-019 Frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity; the first tx=0 cycle SHALL be the cycle after the transfer edge.
REQ-020 Minimum spacing between consecutive transfers SHALL be frame length + 1 cycle (one IDLE cycle with din_ready=1).
REQ-021 The cycle counter SHALL wrap to 0 at CLKS_PER_BIT-1; with CLKS_PER_BIT=1 every bit lasts one cycle.
REQ-022 Changes on din while busy SHALL NOT affect the frame in progress.

Reset
REQ-023 While rst_n=0: state=IDLE, tx=1, din_ready=1, busy=0, counters and shift register 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously); no partial bits SHALL resume after release.
REQ-025 The first transfer SHALL be accepted no earlier than the first posedge after rst_n deasserts.

Configuration
REQ-026 Macro WARN_SERIALIZER_PARITY_EN: when defined, PARITY state SHALL drive tx = XOR of all data bits (even parity) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-027 Without WARN_SERIALIZER_PARITY_EN, no PARITY state or parity logic SHALL exist and DATA SHALL go directly to STOP.

Verification
REQ-028 CLKS_PER_BIT=4, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40-cycle frame; din_ready low for 40 cycles.
REQ-029 PARITY_EN defined, send 0xA5 then 0x01 -> parity bit 0 then 1; frames 44 cycles each.
REQ-030 din_valid held high with 0x3C, 0xC3 back-to-back -> second accepted exactly one cycle after first STOP ends; both frames bit-exact.
REQ-031 rst_n pulsed low at cycle 15 of a 0xFF frame -> tx=1, busy=0, din_ready=1 during reset; no further tx=0 until a new transfer.
REQ-032 CLKS_PER_BIT=1, send 0x80 -> tx = 0,0,0,0,0,0,0,0,1,1 in 10 consecutive cycles.
REQ-033 din changed to 0x00 during a 0xFF frame -> serial data bits remain all 1.
